// File: rtl/enoc_router_pkg.sv
// ENoC shared configuration: packet format, mesh defaults and helpers.
// Imported by the router, its input FIFO and benches.
package enoc_router_pkg;

  function automatic int log2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  localparam int ENOC_NODES       = 16;
  localparam int ENOC_QUEUE_DEPTH = 4;
  localparam int ADDR_W           = log2(ENOC_NODES);
  localparam int DATA_W           = 32;
  localparam int TS_W             = 8;

  localparam int P_CORE  = 0;
  localparam int P_NORTH = 1;
  localparam int P_EAST  = 2;
  localparam int P_SOUTH = 3;
  localparam int P_WEST  = 4;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [ADDR_W-1:0] source;
    logic [ADDR_W-1:0] dest;
    logic              valid;
    logic [TS_W-1:0]   timestamp;
    logic              measure;
  } packet_t;

endpackage

// File: rtl/enoc_router_fifo.sv
// Packet FIFO with a register-file head; a write is visible one edge later.
// Pushes while full are dropped; a same-cycle pop does not make room.
module LIB_FIFO_packet_t
  import enoc_router_pkg::*;
#(
  parameter int DEPTH = ENOC_QUEUE_DEPTH
) (
  input  logic    clk,
  input  logic    ce,
  input  logic    reset_n,
  input  packet_t i_data,
  input  logic    i_data_val,
  input  logic    i_en,
  output packet_t o_data,
  output logic    o_data_val,
  output logic    o_en,
  output logic    o_full,
  output logic    o_empty,
  output logic    o_near_empty
);

  localparam int PW = (DEPTH > 1) ? log2(DEPTH) : 1;
  localparam int CW = log2(DEPTH + 1);

  packet_t         r_mem [DEPTH];
  logic [PW-1:0]   r_rd;
  logic [PW-1:0]   r_wr;
  logic [CW-1:0]   r_cnt;
  logic            w_full;
  logic            w_empty;
  logic            w_push;
  logic            w_pop;

  function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign w_full  = (r_cnt == CW'(DEPTH));
  assign w_empty = (r_cnt == '0);
  assign w_push  = ce & i_data_val & ~w_full;
  assign w_pop   = ce & i_en & ~w_empty;

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr] <= i_data;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_rd  <= '0;
      r_wr  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) r_wr <= inc(r_wr);
      if (w_pop)  r_rd <= inc(r_rd);
      unique case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  assign o_data       = r_mem[r_rd];
  assign o_data_val   = ~w_empty;
  assign o_en         = ~w_full;
  assign o_full       = w_full;
  assign o_empty      = w_empty;
  assign o_near_empty = (r_cnt <= CW'(1));

endmodule

// File: rtl/enoc_router.sv
// 5-port input-buffered XY mesh router: per-input FIFOs, per-output
// round-robin switch allocation, registered crossbar outputs.
module enoc_router
  import enoc_router_pkg::*;
#(
  parameter int NODES             = ENOC_NODES,
  parameter int LOC               = 5,
  parameter int INPUT_QUEUE_DEPTH = ENOC_QUEUE_DEPTH,
  parameter int N                 = 5,
  parameter int M                 = 5
) (
  input  logic                clk,
  input  logic                reset_n,
  input  packet_t [N-1:0]     i_data,
  input  logic    [N-1:0]     i_data_val,
  output logic    [N-1:0]     o_en,
  input  logic    [M-1:0]     i_en,
  output packet_t [M-1:0]     o_data,
  output logic    [M-1:0]     o_data_val
);

  localparam int HW = log2(NODES) / 2;
  localparam int IW = (N > 1) ? log2(N) : 1;
  localparam logic [HW-1:0] LX = HW'(LOC % (2 ** HW));
  localparam logic [HW-1:0] LY = HW'(LOC / (2 ** HW));

  packet_t          w_head [N];
  logic [N-1:0]     w_hval;
  logic [N-1:0]     w_fen;
  logic [N-1:0]     w_pop;
  logic [M-1:0]     w_req [N];
  logic [M-1:0]     w_hit;
  logic [IW-1:0]    w_sel [M];

  packet_t [M-1:0]  r_data;
  logic [M-1:0]     r_val;
  logic [IW-1:0]    r_ptr [M];

  for (genvar i = 0; i < N; i++) begin : g_in
    LIB_FIFO_packet_t #(
      .DEPTH(INPUT_QUEUE_DEPTH)
    ) u_fifo (
      .clk         (clk),
      .ce          (1'b1),
      .reset_n     (reset_n),
      .i_data      (i_data[i]),
      .i_data_val  (i_data_val[i]),
      .i_en        (w_pop[i]),
      .o_data      (w_head[i]),
      .o_data_val  (w_hval[i]),
      .o_en        (w_fen[i]),
      .o_full      (),
      .o_empty     (),
      .o_near_empty()
    );
  end

  assign o_en = {N{reset_n}} & w_fen;

  // X is resolved before Y; equal coordinates eject to the core.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      w_req[i] = '0;
      if (w_hval[i]) begin
        if (w_head[i].dest[HW-1:0] > LX)
          w_req[i][P_EAST] = 1'b1;
        else if (w_head[i].dest[HW-1:0] < LX)
          w_req[i][P_WEST] = 1'b1;
        else if (w_head[i].dest[2*HW-1:HW] > LY)
          w_req[i][P_SOUTH] = 1'b1;
        else if (w_head[i].dest[2*HW-1:HW] < LY)
          w_req[i][P_NORTH] = 1'b1;
        else
          w_req[i][P_CORE] = 1'b1;
      end
    end
  end

  always_comb begin
    w_pop = '0;
    for (int j = 0; j < M; j++) begin
      w_hit[j] = 1'b0;
      w_sel[j] = '0;
      if (~r_val[j] | i_en[j]) begin
        for (int k = 0; k < N; k++) begin
          if (!w_hit[j] &&
              w_req[(int'(r_ptr[j]) + k) % N][j]) begin
            w_hit[j] = 1'b1;
            w_sel[j] = IW'((int'(r_ptr[j]) + k) % N);
          end
        end
      end
      if (w_hit[j]) w_pop[w_sel[j]] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_data <= '0;
      r_val  <= '0;
      for (int j = 0; j < M; j++) r_ptr[j] <= '0;
    end else begin
      for (int j = 0; j < M; j++) begin
        if (w_hit[j]) begin
          r_data[j] <= w_head[w_sel[j]];
          r_val[j]  <= 1'b1;
          r_ptr[j]  <= (w_sel[j] == IW'(N - 1)) ?
                       '0 : w_sel[j] + 1'b1;
        end else if (i_en[j]) begin
          r_val[j] <= 1'b0;
        end
      end
    end
  end

  assign o_data     = r_data;
  assign o_data_val = r_val;

endmodule

// File: tb/tb_enoc_router.sv
// Directed + random bench for enoc_router at LOC 5 with a
// per-output, per-source expected-packet scoreboard.
module tb_enoc_router;
  import enoc_router_pkg::*;

  localparam int N = 5;
  localparam int M = 5;
  localparam int DEPTH = 4;

  logic            clk = 1'b0;
  logic            reset_n = 1'b0;
  packet_t [N-1:0] i_data;
  logic [N-1:0]    i_data_val;
  logic [N-1:0]    o_en;
  logic [M-1:0]    i_en;
  packet_t [M-1:0] o_data;
  logic [M-1:0]    o_data_val;

  int checks = 0;
  int failures = 0;
  int delivered = 0;
  int seq = 0;

  packet_t exp_q [M][N][$];
  logic [M-1:0] held = '0;
  packet_t held_pkt [M];

  enoc_router #(
    .NODES(16), .LOC(5), .INPUT_QUEUE_DEPTH(DEPTH), .N(N), .M(M)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .i_data    (i_data),
    .i_data_val(i_data_val),
    .o_en      (o_en),
    .i_en      (i_en),
    .o_data    (o_data),
    .o_data_val(o_data_val)
  );

  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Local node 5 sits at x=1, y=1.
  function automatic int route(input logic [3:0] d);
    int dx, dy;
    dx = int'(d[1:0]);
    dy = int'(d[3:2]);
    if (dx > 1) return 2;
    if (dx < 1) return 4;
    if (dy > 1) return 3;
    if (dy < 1) return 1;
    return 0;
  endfunction

  function automatic packet_t mk(input int port, input logic [3:0] d);
    packet_t p;
    seq++;
    p = '0;
    p.data = 32'hA500_0000 + 32'(seq);
    p.source = 4'(port);
    p.dest = d;
    p.valid = 1'($urandom);
    p.timestamp = 8'(seq);
    p.measure = 1'($urandom);
    return p;
  endfunction

  function automatic bit all_empty();
    for (int j = 0; j < M; j++)
      for (int i = 0; i < N; i++)
        if (exp_q[j][i].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic stage(input int port, input logic [3:0] d);
    i_data[port] = mk(port, d);
    i_data_val[port] = 1'b1;
  endtask

  task automatic commit(input int port);
    exp_q[route(i_data[port].dest)][port].push_back(i_data[port]);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (reset_n) begin
      for (int j = 0; j < M; j++) begin
        if (held[j]) begin
          chk($sformatf("hold_val%0d", j), 64'(o_data_val[j]), 64'd1);
          chk($sformatf("hold_data%0d", j), 64'(o_data[j]),
              64'(held_pkt[j]));
        end
        if (o_data_val[j] && i_en[j]) begin
          int src;
          src = int'(o_data[j].source);
          if (src < N && exp_q[j][src].size() > 0) begin
            chk($sformatf("deliver_out%0d_src%0d", j, src),
                64'(o_data[j]), 64'(exp_q[j][src].pop_front()));
            delivered++;
          end else begin
            checks++;
            failures++;
            $error("FAIL spurious out=%0d observed=%0h expected=none",
                   j, o_data[j]);
          end
        end
        held[j] <= o_data_val[j] & ~i_en[j];
        held_pkt[j] <= o_data[j];
      end
    end
  end

  initial begin
    int xy_dest [5];
    int xy_port [5];
    int accepted;
    int left [N];
    int total;
    int cyc;
    int d0;
    xy_dest = '{7, 13, 4, 1, 6};
    xy_port = '{2, 3, 4, 1, 2};

    // 1. reset with inputs asserted
    i_en = '1;
    for (int i = 0; i < N; i++) stage(i, 4'd5);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_o_en", 64'(o_en), 64'd0);
    chk("reset_val", 64'(o_data_val), 64'd0);
    chk("reset_data", 64'(o_data == '0), 64'd1);
    tick();
    i_data_val = '0;
    reset_n = 1'b1;
    @(negedge clk);
    chk("post_reset_o_en", 64'(o_en), 64'h1f);
    repeat (2) tick();
    @(negedge clk);
    chk("post_reset_val", 64'(o_data_val), 64'd0);

    // 2. local delivery, latency one edge after push
    tick();
    stage(0, 4'd5);
    commit(0);
    begin
      packet_t p0;
      p0 = i_data[0];
      tick();
      i_data_val = '0;
      @(negedge clk);
      chk("local_no_bypass", 64'(o_data_val), 64'd0);
      @(negedge clk);
      chk("local_val", 64'(o_data_val), 64'h01);
      chk("local_data", 64'(o_data[0]), 64'(p0));
    end
    repeat (3) tick();

    // 3. XY routing
    for (int k = 0; k < 5; k++) begin
      stage(0, 4'(xy_dest[k]));
      commit(0);
      tick();
      i_data_val = '0;
      @(negedge clk);
      @(negedge clk);
      chk($sformatf("xy_dest%0d", xy_dest[k]), 64'(o_data_val),
          64'(1 << xy_port[k]));
      repeat (2) tick();
    end

    // 4. contention on core output, twice
    for (int r = 0; r < 2; r++) begin
      for (int p = 1; p <= 3; p++) begin
        stage(p, 4'd5);
        commit(p);
      end
      tick();
      i_data_val = '0;
      @(negedge clk);
      for (int p = 1; p <= 3; p++) begin
        @(negedge clk);
        chk($sformatf("rr%0d_val", r), 64'(o_data_val[0]), 64'd1);
        chk($sformatf("rr%0d_src", r), 64'(o_data[0].source), 64'(p));
      end
      repeat (3) tick();
    end

    // 5. backpressure on east
    i_en = 5'b11011;
    accepted = 0;
    for (int c = 0; c < 12; c++) begin
      stage(0, 4'd6);
      @(negedge clk);
      if (!o_en[0]) break;
      commit(0);
      accepted++;
      tick();
    end
    i_data_val = '0;
    chk("bp_accepted", 64'(accepted), 64'(DEPTH + 1));
    repeat (3) @(negedge clk);
    chk("bp_o_en_low", 64'(o_en[0]), 64'd0);
    chk("bp_out_held", 64'(o_data_val[2]), 64'd1);
    tick();
    i_en = '1;
    cyc = 0;
    while (!all_empty() && cyc < 50) begin
      tick();
      cyc++;
    end
    chk("bp_drained", 64'(all_empty()), 64'd1);
    repeat (2) tick();

    // 6. random traffic
    d0 = delivered;
    for (int i = 0; i < N; i++) left[i] = 5;
    total = 5 * N;
    cyc = 0;
    while (total > 0 && cyc < 3000) begin
      i_en = M'($urandom);
      for (int i = 0; i < N; i++) begin
        if (left[i] > 0 && $urandom_range(1, 0) == 1)
          stage(i, 4'($urandom_range(15, 0)));
        else
          i_data_val[i] = 1'b0;
      end
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
        if (i_data_val[i] && o_en[i]) begin
          commit(i);
          left[i]--;
          total--;
        end
      end
      tick();
      cyc++;
    end
    i_data_val = '0;
    chk("rand_injected", 64'(total), 64'd0);
    i_en = '1;
    cyc = 0;
    while (!all_empty() && cyc < 200) begin
      tick();
      cyc++;
    end
    repeat (2) tick();
    chk("rand_drained", 64'(all_empty()), 64'd1);
    chk("rand_delivered", 64'(delivered - d0), 64'(5 * N));
    chk("idle_val", 64'(o_data_val), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
